// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (video read / cpu read-write) arbiter for an
// asynchronous SRAM. Every transfer is ACCESS (WAIT_CYCLES+1 cycles) followed
// by one TURN cycle; arbitration happens in IDLE and TURN so back-to-back
// transfers have no idle gap.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for alternating priority on
// simultaneous requests; otherwise video has fixed priority over cpu.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [19:0] vid_addr,
    output logic        vid_gnt,
    output logic [15:0] vid_rdata,
    output logic        vid_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_be_n,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic [19:0] SRAM_ADDR,
    output logic [1:0]  SRAM_BE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_owner_cpu;
    logic        r_we;
    logic [19:0] r_addr;
    logic [1:0]  r_be_n;
    logic [15:0] r_wdata;
    logic        r_oe_n, r_we_n, r_ce_n, r_dq_oe;
    logic        r_vid_gnt, r_cpu_gnt, r_vid_rvalid, r_cpu_done;
    logic [15:0] r_vid_rdata, r_cpu_rdata;

    logic        w_any;
    logic        w_pick_cpu;
    logic        w_wr;
    logic        w_last;

    assign w_any  = vid_req | cpu_req;
    assign w_wr   = w_pick_cpu & cpu_we;
    assign w_last = (r_cnt == 3'(WAIT_CYCLES));

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = cpu was not granted most recently, so cpu wins a tie
    logic r_prio_cpu;
    assign w_pick_cpu = cpu_req & (~vid_req | r_prio_cpu);

    // pointer moves only when a grant is issued
    always_ff @(posedge clk) begin
        if (reset)
            r_prio_cpu <= 1'b0;
        else if ((r_state != ACCESS) && w_any)
            r_prio_cpu <= ~w_pick_cpu;
    end
`else
    // video always wins a tie; cpu may be starved by continuous video traffic
    assign w_pick_cpu = cpu_req & ~vid_req;
`endif

    // transfer FSM; every SRAM strobe and handshake output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner_cpu  <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be_n       <= 2'b11;
            r_wdata      <= '0;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_ce_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
            r_vid_gnt    <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_vid_rvalid <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_vid_rdata  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_vid_gnt    <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_vid_rvalid <= 1'b0;
            r_cpu_done   <= 1'b0;
            case (r_state)
                IDLE, TURN: begin
                    if (w_any) begin
                        r_state     <= ACCESS;
                        r_cnt       <= '0;
                        r_owner_cpu <= w_pick_cpu;
                        r_we        <= w_wr;
                        r_addr      <= w_pick_cpu ? cpu_addr : vid_addr;
                        r_be_n      <= w_pick_cpu ? cpu_be_n : 2'b00;
                        r_wdata     <= cpu_wdata;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= w_wr;
                        r_we_n      <= ~w_wr;
                        r_dq_oe     <= w_wr;
                        r_vid_gnt   <= ~w_pick_cpu;
                        r_cpu_gnt   <= w_pick_cpu;
                    end else begin
                        r_state <= IDLE;
                        r_dq_oe <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (w_last) begin
                        // strobes rise here; dq_oe stays up through TURN for writes
                        r_state <= TURN;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        if (r_we) begin
                            r_cpu_done <= 1'b1;
                        end else if (r_owner_cpu) begin
                            r_cpu_rdata <= sram_dq_i;
                            r_cpu_done  <= 1'b1;
                        end else begin
                            r_vid_rdata  <= sram_dq_i;
                            r_vid_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vid_gnt    = r_vid_gnt;
    assign vid_rdata  = r_vid_rdata;
    assign vid_rvalid = r_vid_rvalid;
    assign cpu_gnt    = r_cpu_gnt;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_done   = r_cpu_done;
    assign SRAM_ADDR  = r_addr;
    assign SRAM_BE_N  = r_be_n;
    assign SRAM_OE_N  = r_oe_n;
    assign SRAM_WE_N  = r_we_n;
    assign SRAM_CE_N  = r_ce_n;
    assign sram_dq_o  = r_wdata;
    assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter with WAIT_CYCLES=1 (dut)
// and WAIT_CYCLES=0 (dut0). Expected arbitration order follows the
// SRAM_ARB_ROUND_ROBIN_EN build option.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset, vid_req, cpu_req, cpu_we;
    logic [19:0] vid_addr, cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_be_n;
    logic        vid_gnt, vid_rvalid, cpu_gnt, cpu_done;
    logic [15:0] vid_rdata, cpu_rdata;
    logic [19:0] SRAM_ADDR;
    logic [1:0]  SRAM_BE_N;
    logic        SRAM_OE_N, SRAM_WE_N, SRAM_CE_N, sram_dq_oe;
    logic [15:0] sram_dq_o, sram_dq_i;

    logic        rst0, vid_req0;
    logic        vid_gnt0, vid_rvalid0, cpu_gnt0, cpu_done0;
    logic [15:0] vid_rdata0, cpu_rdata0, sram_dq_o0;
    logic [19:0] SRAM_ADDR0;
    logic [1:0]  SRAM_BE_N0;
    logic        SRAM_OE_N0, SRAM_WE_N0, SRAM_CE_N0, sram_dq_oe0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // SRAM read model: fixed pattern per address, driven only while read-enabled
    function automatic logic [15:0] mem(input logic [19:0] a);
        return (a == 20'h12345) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction
    assign sram_dq_i = (!SRAM_CE_N && !SRAM_OE_N) ? mem(SRAM_ADDR) : 16'h0000;

    sram_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be_n(cpu_be_n), .cpu_gnt(cpu_gnt),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_BE_N(SRAM_BE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    sram_arbiter #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0),
        .vid_req(vid_req0), .vid_addr(20'h00777), .vid_gnt(vid_gnt0),
        .vid_rdata(vid_rdata0), .vid_rvalid(vid_rvalid0),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(20'h0),
        .cpu_wdata(16'h0), .cpu_be_n(2'b11), .cpu_gnt(cpu_gnt0),
        .cpu_rdata(cpu_rdata0), .cpu_done(cpu_done0),
        .SRAM_ADDR(SRAM_ADDR0), .SRAM_BE_N(SRAM_BE_N0), .SRAM_OE_N(SRAM_OE_N0),
        .SRAM_WE_N(SRAM_WE_N0), .SRAM_CE_N(SRAM_CE_N0), .sram_dq_o(sram_dq_o0),
        .sram_dq_oe(sram_dq_oe0), .sram_dq_i(16'h1234)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock and settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_strobes(input string tag);
        chk({tag, "_ce"}, SRAM_CE_N, 1'b1);
        chk({tag, "_oe"}, SRAM_OE_N, 1'b1);
        chk({tag, "_we"}, SRAM_WE_N, 1'b1);
    endtask

    initial begin
        int ng, cyc, last, ndone;
        logic rr;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        reset = 1'b1; rst0 = 1'b1; vid_req0 = 1'b0;
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        vid_addr = '0; cpu_addr = '0; cpu_wdata = '0; cpu_be_n = 2'b11;
        tick(); tick();

        // reset values
        chk_idle_strobes("rst");
        chk("rst_dqoe", sram_dq_oe, 1'b0);
        chk("rst_addr", SRAM_ADDR, 20'h0);
        chk("rst_be", SRAM_BE_N, 2'b11);
        chk("rst_hs", {vid_gnt, vid_rvalid, cpu_gnt, cpu_done}, 4'b0000);
        chk("rst_rd", {vid_rdata, cpu_rdata}, 32'h0);
        reset = 1'b0;
        tick();

        // cpu write: WE_N low 2 cycles, dq_oe high 3, done on 3rd cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00010;
        cpu_wdata = 16'hA5A5; cpu_be_n = 2'b00;
        tick();
        chk("wr_gnt", cpu_gnt, 1'b1);
        chk("wr_a1", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, sram_dq_oe}, 4'b0101);
        chk("wr_addr", SRAM_ADDR, 20'h00010);
        chk("wr_be", SRAM_BE_N, 2'b00);
        chk("wr_data", sram_dq_o, 16'hA5A5);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        chk("wr_a2", {cpu_gnt, SRAM_CE_N, SRAM_WE_N, sram_dq_oe, cpu_done}, 5'b00010);
        tick();
        chk("wr_turn", {SRAM_CE_N, SRAM_WE_N, sram_dq_oe, cpu_done}, 4'b1111);
        chk("wr_turn_addr", SRAM_ADDR, 20'h00010);
        tick();
        chk("wr_idle", {sram_dq_oe, cpu_done}, 2'b00);
        chk_idle_strobes("wr_idle");

        // video read of 0x12345 returns 0xBEEF two cycles after gnt
        vid_req = 1'b1; vid_addr = 20'h12345;
        tick();
        chk("vr_gnt", vid_gnt, 1'b1);
        chk("vr_a1", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N}, 5'b00100);
        vid_req = 1'b0;
        tick();
        chk("vr_a2", {vid_gnt, SRAM_WE_N, vid_rvalid}, 3'b010);
        tick();
        chk("vr_turn", {vid_rvalid, SRAM_WE_N}, 2'b11);
        chk("vr_data", vid_rdata, 16'hBEEF);
        tick();
        chk("vr_hold", {vid_rvalid, vid_rdata}, {1'b0, 16'hBEEF});

        // simultaneous continuous requests, six grants
        reset = 1'b1; tick(); reset = 1'b0;
        vid_req = 1'b1; vid_addr = 20'h00040;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00020;
        ng = 0; cyc = 0; last = 0; ndone = 0;
        while (ng < 6 && cyc < 40) begin
            tick(); cyc++;
            if (cpu_done) ndone++;
            if (vid_gnt | cpu_gnt) begin
                chk("arb_who", {vid_gnt, cpu_gnt}, (rr && ng[0]) ? 2'b01 : 2'b10);
                if (ng > 0) chk("arb_gap", cyc - last, 3);
                last = cyc;
                ng++;
            end
        end
        chk("arb_count", ng, 6);
        vid_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_done) ndone++;
        end
        chk("arb_done", ndone, rr ? 3 : 0);

        // cpu request arriving during a video ACCESS follows its TURN directly
        vid_req = 1'b1; vid_addr = 20'h00100;
        tick();
        chk("pend_vgnt", vid_gnt, 1'b1);
        vid_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00200;
        tick();
        tick();
        chk("pend_turn", {vid_rvalid, cpu_gnt}, 2'b10);
        chk("pend_vdata", vid_rdata, mem(20'h00100));
        tick();
        chk("pend_cgnt", {cpu_gnt, SRAM_CE_N}, 2'b10);
        chk("pend_caddr", SRAM_ADDR, 20'h00200);
        cpu_req = 1'b0;
        tick();
        tick();
        chk("pend_done", cpu_done, 1'b1);
        chk("pend_cdata", cpu_rdata, mem(20'h00200));
        tick();

        // reset in second ACCESS cycle of a cpu read aborts it
        cpu_req = 1'b1; cpu_addr = 20'h00300;
        tick();
        chk("abort_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_idle_strobes("abort");
        chk("abort_hs", {cpu_done, cpu_gnt, sram_dq_oe}, 3'b000);
        reset = 1'b0;
        tick();
        chk("abort_nodone", cpu_done, 1'b0);
        cpu_req = 1'b1;
        tick();
        chk("reissue_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        tick();
        tick();
        chk("reissue_done", cpu_done, 1'b1);
        chk("reissue_data", cpu_rdata, mem(20'h00300));

        // WAIT_CYCLES=0 with continuous video: grant every 2 cycles
        rst0 = 1'b0; vid_req0 = 1'b1;
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vid_gnt0) ng++;
            if (i % 2 == 0) begin
                chk("w0_acc", {vid_gnt0, SRAM_CE_N0, vid_rvalid0}, 3'b100);
            end else begin
                chk("w0_turn", {vid_gnt0, SRAM_CE_N0, vid_rvalid0}, 3'b011);
                chk("w0_data", vid_rdata0, 16'h1234);
            end
        end
        chk("w0_count", ng, 6);
        vid_req0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of extra SRAM access cycles beyond the first; legal range is 0..7.
REQ-002 SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, width 1, a synchronous, active-high reset.
REQ-004 SHALL have vid_req (in, 1), vid_addr (in, 20), vid_gnt (out, 1), vid_rdata (out, 16) and vid_rvalid (out, 1), forming the read-only video fetch port.
REQ-005 SHALL have cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, 20), cpu_wdata (in, 16), cpu_be_n (in, 2), cpu_gnt (out, 1), cpu_rdata (out, 16) and cpu_done (out, 1), forming the processor read/write port.
REQ-006 SHALL have SRAM_ADDR (out, 20), SRAM_BE_N (out, 2), SRAM_OE_N (out, 1), SRAM_WE_N (out, 1), SRAM_CE_N (out, 1), sram_dq_o (out, 16), sram_dq_oe (out, 1) and sram_dq_i (in, 16); the tristate buffer is built at the top level.

Function
REQ-007 SHALL implement an FSM with three states:
- IDLE: no transfer in progress.
- ACCESS: lasts exactly WAIT_CYCLES+1 cycles.
- TURN: lasts exactly 1 cycle.
REQ-008 SHALL arbitrate in IDLE and in TURN; if any request is pending, the next state is ACCESS, otherwise IDLE.
REQ-009 On the edge entering ACCESS, SHALL latch the winner's address, byte enables, write enable and write data, and SHALL pulse that port's gnt high for the first ACCESS cycle only.
REQ-010 A requester SHALL hold req and its request fields stable until it sees gnt; on the gnt cycle it may drop req or present a new request.
REQ-011 Read transfer:
- SRAM_CE_N and SRAM_OE_N are low for all ACCESS cycles.
- sram_dq_i is captured at the end of the last ACCESS cycle.
- rdata is presented with a one-cycle rvalid/done pulse during TURN.
REQ-012 Write transfer:
- SRAM_CE_N and SRAM_WE_N are low for all ACCESS cycles.
- sram_dq_oe is high during ACCESS and TURN, so data is held one cycle after the rising edge of SRAM_WE_N.
- cpu_done pulses during TURN.
REQ-013 SRAM_ADDR and SRAM_BE_N SHALL stay stable from ACCESS entry through the end of TURN; video reads drive SRAM_BE_N = 2'b00.
REQ-014 The minimum transfer length SHALL be WAIT_CYCLES+2 cycles; back-to-back transfers proceed TURN -> ACCESS with no IDLE cycle between them.
REQ-015 Outside ACCESS, SHALL hold SRAM_OE_N, SRAM_WE_N and SRAM_CE_N high; sram_dq_oe is low except as required by REQ-012.
REQ-016 vid_rdata and cpu_rdata SHALL hold their last captured value until the next read on the same port.
REQ-017 A request arriving during ACCESS SHALL wait and be arbitrated in TURN; requests are never dropped.
REQ-018 cpu_we SHALL be ignored while cpu_req is low; vid_req has no write capability.

Reset
REQ-019 When reset is high at an edge, on the next cycle the block SHALL be in state IDLE with these output values:
- SRAM_OE_N = 1, SRAM_WE_N = 1, SRAM_CE_N = 1.
- sram_dq_oe = 0.
- SRAM_ADDR = 0, SRAM_BE_N = 2'b11.
- all gnt, rvalid and done outputs = 0.
- vid_rdata = 0, cpu_rdata = 0.
- the round-robin pointer selects video first.
REQ-020 Reset during ACCESS or TURN SHALL abort the transfer with no rvalid/done pulse; the requester re-issues its request after reset.

Configuration
REQ-021 With SRAM_ARB_ROUND_ROBIN_EN defined, SHALL resolve simultaneous requests by alternation:
- The port not granted most recently wins.
- The pointer updates only on a grant.
- A lone requester always wins.
REQ-022 Without SRAM_ARB_ROUND_ROBIN_EN, SHALL give video fixed priority over cpu; continuous vid_req may starve cpu, and this is the accepted behaviour.

Verification
REQ-023 WAIT_CYCLES=1; cpu write addr 0x00010, data 0xA5A5, be_n 2'b00 -> SRAM_WE_N low 2 cycles, sram_dq_oe high 3 cycles, cpu_done on cycle 3 after gnt.
REQ-024 vid read addr 0x12345, model returns 0xBEEF -> vid_rvalid pulses 2 cycles after vid_gnt with vid_rdata = 0xBEEF; SRAM_WE_N stays high throughout.
REQ-025 vid_req and cpu_req both held high for 6 transfers -> with the macro, grants go V,C,V,C,V,C; without the macro, grants go V×6 and cpu_done never pulses.
REQ-026 WAIT_CYCLES=0, vid_req held high continuously -> one grant every 2 cycles, and SRAM_CE_N is never high between transfers during ACCESS.
REQ-027 reset asserted in the second ACCESS cycle of a cpu read -> no cpu_done pulse, all SRAM strobes high on the following cycle; cpu re-request completes normally.
REQ-028 cpu_req rises during a video ACCESS -> cpu_gnt in the cycle after the video TURN, with no idle gap between the two transfers.
